// File: rtl/fetch_unit_if.sv
// fetch_unit_if - bundle of the fetch unit's memory, core and redirect channels.
//
// Signals:
//   imem_req_valid/ready/addr : word read request to instruction memory
//   imem_rsp_valid/data       : in-order read response, never back-pressured
//   ins_valid/ready/ins/ins_pc: instruction handed to the core
//   redirect_valid/pc         : branch/jump target from the core
//   fetch_err                 : misaligned-redirect flag (only with FETCH_ALIGN_CHECK_EN)
//
// Modports:
//   master : the fetch unit side
//   slave  : the environment side (memory + core)
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the fetch_err signal.

interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    modport master (
`ifdef FETCH_ALIGN_CHECK_EN
        output fetch_err,
`endif
        output imem_req_valid,
        output imem_req_addr,
        output ins_valid,
        output ins,
        output ins_pc,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  ins_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
        input  fetch_err,
`endif
        input  imem_req_valid,
        input  imem_req_addr,
        input  ins_valid,
        input  ins,
        input  ins_pc,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output ins_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch front end.
//
// Keeps the fetch PC, issues word reads to instruction memory, buffers the
// in-order responses in a small FIFO and presents the head word plus its PC
// to the core. A redirect flushes the FIFO, reloads the PCs and turns every
// request still in flight into a response that is silently discarded.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (memory request/response, instruction
//           output, redirect input, optional fetch_err)
//
// Parameters:
//   RESET_PC   : fetch PC after reset
//   FIFO_DEPTH : buffer entries (power of two, >= 2); also bounds the number
//                of requests in flight
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN - a redirect to a non word
// aligned target raises fetch_err and parks the unit in ERR until reset.
// Without it the low two target bits are ignored.

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Wide enough to add three CW-bit counters without overflow.
    localparam int SW = CW + 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [31:0]     fetch_pc_r, fetch_pc_nxt_s;
    logic [31:0]     rsp_pc_r, rsp_pc_nxt_s;
    logic [CW-1:0]   outstanding_r, outstanding_nxt_s;
    logic [CW-1:0]   drop_cnt_r, drop_cnt_nxt_s;
    logic [CW-1:0]   count_r, count_nxt_s;
    logic [AW-1:0]   rd_ptr_r, rd_ptr_nxt_s;
    logic [AW-1:0]   wr_ptr_r, wr_ptr_nxt_s;
    logic [31:0]     pc_mem_r   [FIFO_DEPTH];
    logic [31:0]     data_mem_r [FIFO_DEPTH];

    logic            redirect_s;
    logic            misalign_s;
    logic [31:0]     target_s;
    logic [SW-1:0]   used_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_drop_s;
    logic            rsp_take_s;
    logic            push_s;
    logic            pop_s;
    logic            flush_s;

    // Redirects are meaningless once parked in ERR; only reset leaves it.
    assign redirect_s = bus.redirect_valid && (state_r != ERR);
    // Low two bits are always cleared, so a misaligned target fetches its word.
    assign target_s   = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_s = redirect_s && (bus.redirect_pc[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // Buffered words, live requests and stale requests all consume a slot:
    // every request ever issued is guaranteed space when its word returns.
    assign used_s      = SW'(count_r) + SW'(outstanding_r) + SW'(drop_cnt_r);
    assign req_valid_s = (state_r == RUN) && !bus.redirect_valid &&
                         (used_s < SW'(FIFO_DEPTH));
    assign req_fire_s  = req_valid_s && bus.imem_req_ready;

    // Responses are in order, so the oldest drop_cnt_r words are the stale ones.
    assign rsp_drop_s  = bus.imem_rsp_valid && (drop_cnt_r != {CW{1'b0}});
    assign rsp_take_s  = bus.imem_rsp_valid && (drop_cnt_r == {CW{1'b0}});
    // A live word arriving with a redirect is already stale and is not kept.
    assign push_s      = rsp_take_s && !redirect_s && (state_r != ERR);
    assign pop_s       = (count_r != {CW{1'b0}}) && bus.ins_ready;
    assign flush_s     = redirect_s || (state_r == ERR);

    // Next-state and next-counter logic.
    always_comb begin
        state_nxt_s       = state_r;
        fetch_pc_nxt_s    = fetch_pc_r;
        rsp_pc_nxt_s      = rsp_pc_r;
        outstanding_nxt_s = outstanding_r;
        drop_cnt_nxt_s    = drop_cnt_r;
        count_nxt_s       = count_r;
        rd_ptr_nxt_s      = rd_ptr_r;
        wr_ptr_nxt_s      = wr_ptr_r;

        case (state_r)
            BOOT: begin
                if (misalign_s) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (misalign_s) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            ERR: begin
                state_nxt_s = ERR;
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase

        if (redirect_s) begin
            fetch_pc_nxt_s    = target_s;
            rsp_pc_nxt_s      = target_s;
            // The word handled this cycle is retired before the rest of the
            // in-flight requests are reclassified as stale.
            drop_cnt_nxt_s    = (drop_cnt_r - CW'(rsp_drop_s)) +
                                (outstanding_r - CW'(rsp_take_s));
            outstanding_nxt_s = {CW{1'b0}};
        end else begin
            if (req_fire_s) begin
                fetch_pc_nxt_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (push_s) begin
                rsp_pc_nxt_s = rsp_pc_r + 32'd4;
            end else begin
                rsp_pc_nxt_s = rsp_pc_r;
            end
            drop_cnt_nxt_s    = drop_cnt_r - CW'(rsp_drop_s);
            outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(rsp_take_s);
        end

        if (flush_s) begin
            count_nxt_s  = {CW{1'b0}};
            rd_ptr_nxt_s = {AW{1'b0}};
            wr_ptr_nxt_s = {AW{1'b0}};
        end else begin
            count_nxt_s  = count_r + CW'(push_s) - CW'(pop_s);
            rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
            wr_ptr_nxt_s = wr_ptr_r + AW'(push_s);
        end
    end

    // Control state, PCs, credit counters and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_cnt_r    <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            rsp_pc_r      <= rsp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
            count_r       <= count_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
        end
    end

    // FIFO storage; reset values make ins/ins_pc read 0/RESET_PC out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_r[i]   <= RESET_PC;
                data_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
            data_mem_r[wr_ptr_r] <= bus.imem_rsp_data;
        end else begin
            pc_mem_r[wr_ptr_r]   <= pc_mem_r[wr_ptr_r];
            data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetch_err_r;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_r <= 1'b0;
        end else if (misalign_s) begin
            fetch_err_r <= 1'b1;
        end else begin
            fetch_err_r <= fetch_err_r;
        end
    end

    assign bus.fetch_err = fetch_err_r;
`endif

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.ins_valid      = (count_r != {CW{1'b0}});
    assign bus.ins            = data_mem_r[rd_ptr_r];
    assign bus.ins_pc         = pc_mem_r[rd_ptr_r];

endmodule
